conv_beat_packer: RTL

Feeder for the Gaussian convolution stage (`CONV_GAUSS`). It takes a one-pixel-per-cycle valid/ready stream and packs `PIXELS_PER_BEAT` pixels into one beat. It drives the `stall`/data pair that the convolution consumes: `stall` is low only in cycles that carry a fresh beat. After the last beat of each `IMAGE_DIM`×`IMAGE_DIM` frame, it injects zero-valued flush beats so the convolution pipeline drains before the next frame.

---
 rtl/conv_beat_packer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/conv_beat_packer.sv
// conv_beat_packer: packs a one-pixel-per-cycle valid/ready stream into
// PIXELS_PER_BEAT-pixel beats for the Gaussian convolution stage. The output
// is a stall/data pair. FLUSH_BEATS zero beats follow each frame so that the
// convolution pipeline drains.
// Optional feature: define CONV_PACKER_MARKERS_EN to drive sof/eol/eof.
// Without it the markers are tied to 0.
module conv_beat_packer #(
   parameter int unsigned PIXELS_PER_BEAT = 8,
   parameter int unsigned IMAGE_DIM       = 64,
   parameter int unsigned DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
   parameter int unsigned FLUSH_BEATS     = 16
) (
   input  logic                  clk,
   input  logic                  areset,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [7:0]            s_pixel,
   output logic                  stall,
   output logic [DATA_WIDTH-1:0] out_frame,
   output logic                  sof,
   output logic                  eol,
   output logic                  eof
);

   localparam int unsigned BPR = IMAGE_DIM / PIXELS_PER_BEAT;
   localparam int unsigned BPF = BPR * IMAGE_DIM;
   localparam int unsigned PCW = (PIXELS_PER_BEAT > 1) ? $clog2(PIXELS_PER_BEAT) : 1;
   localparam int unsigned BCW = (BPF > 1) ? $clog2(BPF) : 1;
   localparam int unsigned FCW = (FLUSH_BEATS > 1) ? $clog2(FLUSH_BEATS) : 1;

   localparam logic [0:0] ST_FILL  = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   logic [0:0]            r_state;
   logic [PCW-1:0]        r_pix_cnt;
   logic [BCW-1:0]        r_beat_cnt;
   logic [FCW-1:0]        r_flush_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] r_out;
   logic                  r_stall;
   logic                  r_sof;
   logic                  r_eol;
   logic                  r_eof;

   logic [0:0]            w_state_nxt;
   logic [PCW-1:0]        w_pix_nxt;
   logic [BCW-1:0]        w_beat_nxt;
   logic [FCW-1:0]        w_flush_nxt;
   logic [DATA_WIDTH-1:0] w_shift_nxt;
   logic [DATA_WIDTH-1:0] w_out_nxt;
   logic                  w_stall_nxt;
   logic                  w_sof_nxt;
   logic                  w_eol_nxt;
   logic                  w_eof_nxt;
   logic [DATA_WIDTH-1:0] w_shifted;
   logic                  w_last_pix;
   logic                  w_last_beat;

   assign w_shifted   = DATA_WIDTH'({r_shift, s_pixel});
   assign w_last_pix  = (r_pix_cnt == PCW'(PIXELS_PER_BEAT - 1));
   assign w_last_beat = (r_beat_cnt == BCW'(BPF - 1));

   // Ready depends on the state register only, never on s_valid.
   assign s_ready   = (r_state == ST_FILL);
   assign stall     = r_stall;
   assign out_frame = r_out;
   assign sof       = r_sof;
   assign eol       = r_eol;
   assign eof       = r_eof;

   // Next-state and next-output decode; no beat means stall and hold data.
   always_comb begin
      w_state_nxt = r_state;
      w_pix_nxt   = r_pix_cnt;
      w_beat_nxt  = r_beat_cnt;
      w_flush_nxt = r_flush_cnt;
      w_shift_nxt = r_shift;
      w_out_nxt   = r_out;
      w_stall_nxt = 1'b1;
      w_sof_nxt   = 1'b0;
      w_eol_nxt   = 1'b0;
      w_eof_nxt   = 1'b0;
      case (r_state)
         ST_FILL: begin
            if (s_valid) begin
               w_shift_nxt = w_shifted;
               if (w_last_pix) begin
                  w_pix_nxt   = '0;
                  w_out_nxt   = w_shifted;
                  w_stall_nxt = 1'b0;
`ifdef CONV_PACKER_MARKERS_EN
                  w_sof_nxt   = (r_beat_cnt == '0);
                  w_eol_nxt   = ((32'(r_beat_cnt) % BPR) == (BPR - 1));
                  w_eof_nxt   = w_last_beat;
`endif
                  if (w_last_beat) begin
                     w_beat_nxt = '0;
                     if (FLUSH_BEATS > 0) begin
                        w_state_nxt = ST_FLUSH;
                        w_flush_nxt = '0;
                     end
                  end else begin
                     w_beat_nxt = r_beat_cnt + BCW'(1);
                  end
               end else begin
                  w_pix_nxt = r_pix_cnt + PCW'(1);
               end
            end
         end
         ST_FLUSH: begin
            w_out_nxt   = '0;
            w_stall_nxt = 1'b0;
            if (r_flush_cnt == FCW'(FLUSH_BEATS - 1)) begin
               w_state_nxt = ST_FILL;
               w_flush_nxt = '0;
            end else begin
               w_flush_nxt = r_flush_cnt + FCW'(1);
            end
         end
         default: begin
            w_state_nxt = ST_FILL;
         end
      endcase
   end

   // State, counters and registered outputs; reset discards any partial beat.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_state     <= ST_FILL;
         r_pix_cnt   <= '0;
         r_beat_cnt  <= '0;
         r_flush_cnt <= '0;
         r_shift     <= '0;
         r_out       <= '0;
         r_stall     <= 1'b1;
         r_sof       <= 1'b0;
         r_eol       <= 1'b0;
         r_eof       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pix_cnt   <= w_pix_nxt;
         r_beat_cnt  <= w_beat_nxt;
         r_flush_cnt <= w_flush_nxt;
         r_shift     <= w_shift_nxt;
         r_out       <= w_out_nxt;
         r_stall     <= w_stall_nxt;
         r_sof       <= w_sof_nxt;
         r_eol       <= w_eol_nxt;
         r_eof       <= w_eof_nxt;
      end
   end

endmodule
